// File: rtl/burst_vc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : burst_vc_fifo
// Purpose  : NUM_CH independent whole-burst queues of DEPTH records each.
//            The optional sticky per-queue error flags are built only when
//            BURST_VC_FIFO_ERR_EN is defined.
// Revision : 1.0
// ============================================================================
module burst_vc_fifo #(
    parameter  int NUM_CH    = 4,
    parameter  int DEPTH     = 16,
    parameter  int ENTRY_W   = 2122,
    parameter  int AFULL_LVL = DEPTH - 2,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [CH_W-1:0]           wr_ch,
    input  logic [ENTRY_W-1:0]        din,
    input  logic                      rd_en,
    input  logic [CH_W-1:0]           rd_ch,
    input  logic [NUM_CH-1:0]         flush,
    output logic [ENTRY_W-1:0]        dout,
    output logic                      dout_vld,
    output logic [NUM_CH-1:0]         alloc_gnt,
    output logic [NUM_CH-1:0]         free_ack,
    output logic [NUM_CH-1:0]         empty,
    output logic [NUM_CH-1:0]         full,
    output logic [NUM_CH-1:0]         almost_full,
`ifdef BURST_VC_FIFO_ERR_EN
    output logic [NUM_CH*CNT_W-1:0]   count,
    output logic [NUM_CH-1:0]         err
`else
    output logic [NUM_CH*CNT_W-1:0]   count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [NUM_CH-1:0]              push_vec;
    logic [NUM_CH-1:0]              pop_vec;
    logic [NUM_CH-1:0][ENTRY_W-1:0] head;

    logic [NUM_CH-1:0] alloc_gnt_q, alloc_gnt_d;
    logic [NUM_CH-1:0] free_ack_q,  free_ack_d;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ENTRY_W-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]   count_q, count_d;
        logic               wr_sel, rd_sel;

        // An out-of-range wr_ch/rd_ch never matches any queue index.
        assign wr_sel = wr_en & (wr_ch == CH_W'(c));
        assign rd_sel = rd_en & (rd_ch == CH_W'(c));

        assign empty[c]       = (count_q == '0);
        assign full[c]        = (count_q == CNT_W'(DEPTH));
        assign almost_full[c] = (count_q >= CNT_W'(AFULL_LVL));

        assign pop_vec[c]  = rd_sel & ~empty[c] & ~flush[c];
        // A full queue still takes a push when its own head leaves this cycle.
        assign push_vec[c] = wr_sel & ~flush[c] & (~full[c] | pop_vec[c]);

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (flush[c]) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end else begin
                if (push_vec[c]) begin
                    wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
                end
                if (pop_vec[c]) begin
                    rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
                end
                if (push_vec[c] && !pop_vec[c]) begin
                    count_d = count_q + CNT_W'(1);
                end else if (pop_vec[c] && !push_vec[c]) begin
                    count_d = count_q - CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        always_ff @(posedge clk) begin
            if (push_vec[c]) begin
                mem_q[wr_ptr_q] <= din;
            end
        end

        assign head[c]                 = mem_q[rd_ptr_q];
        assign count[c*CNT_W +: CNT_W] = count_q;

`ifdef BURST_VC_FIFO_ERR_EN
        logic err_q, err_d;
        logic err_set;

        // A rejection in the same cycle as a flush still leaves the flag set.
        assign err_set = (wr_sel & ~push_vec[c]) | (rd_sel & empty[c]);

        always_comb begin
            err_d = err_q;
            if (flush[c]) begin
                err_d = 1'b0;
            end
            if (err_set) begin
                err_d = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                err_q <= 1'b0;
            end else begin
                err_q <= err_d;
            end
        end

        assign err[c] = err_q;
`endif
    end

    always_comb begin
        alloc_gnt_d = push_vec;
        free_ack_d  = pop_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_gnt_q <= '0;
            free_ack_q  <= '0;
        end else begin
            alloc_gnt_q <= alloc_gnt_d;
            free_ack_q  <= free_ack_d;
        end
    end

    assign alloc_gnt = alloc_gnt_q;
    assign free_ack  = free_ack_q;

    always_comb begin
        dout     = '0;
        dout_vld = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                dout     = head[i];
                dout_vld = ~empty[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_burst_vc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_vc_fifo
// Purpose  : Scoreboard bench for burst_vc_fifo against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_burst_vc_fifo;

    localparam int NUM_CH    = 4;
    localparam int DEPTH     = 16;
    localparam int ENTRY_W   = 2122;
    localparam int AFULL_LVL = DEPTH - 2;
    localparam int CH_W      = 2;
    localparam int CNT_W     = 5;

    typedef logic [ENTRY_W-1:0] ent_t;

    typedef struct {
        logic [NUM_CH-1:0]       alloc;
        logic [NUM_CH-1:0]       free;
        logic [NUM_CH-1:0]       empty;
        logic [NUM_CH-1:0]       full;
        logic [NUM_CH-1:0]       afull;
        logic [NUM_CH-1:0]       err;
        logic [NUM_CH*CNT_W-1:0] cnt;
        logic                    vld;
        ent_t                    dout;
    } exp_t;

    logic                    clk;
    logic                    rst_n;
    logic                    wr_en;
    logic [CH_W-1:0]         wr_ch;
    ent_t                    din;
    logic                    rd_en;
    logic [CH_W-1:0]         rd_ch;
    logic [NUM_CH-1:0]       flush;
    ent_t                    dout;
    logic                    dout_vld;
    logic [NUM_CH-1:0]       alloc_gnt;
    logic [NUM_CH-1:0]       free_ack;
    logic [NUM_CH-1:0]       empty;
    logic [NUM_CH-1:0]       full;
    logic [NUM_CH-1:0]       almost_full;
    logic [NUM_CH*CNT_W-1:0] count;
`ifdef BURST_VC_FIFO_ERR_EN
    logic [NUM_CH-1:0]       err;
`endif

    burst_vc_fifo #(
        .NUM_CH   (NUM_CH),
        .DEPTH    (DEPTH),
        .ENTRY_W  (ENTRY_W),
        .AFULL_LVL(AFULL_LVL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .din        (din),
        .rd_en      (rd_en),
        .rd_ch      (rd_ch),
        .flush      (flush),
        .dout       (dout),
        .dout_vld   (dout_vld),
        .alloc_gnt  (alloc_gnt),
        .free_ack   (free_ack),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
`ifdef BURST_VC_FIFO_ERR_EN
        .count      (count),
        .err        (err)
`else
        .count      (count)
`endif
    );

    // Reference model: one queue of records per channel.
    ent_t              mq [NUM_CH][$];
    logic [NUM_CH-1:0] alloc_m;
    logic [NUM_CH-1:0] free_m;
    logic [NUM_CH-1:0] err_m;
    exp_t              expq [$];

    int n_chk;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic ent_t rnd_ent();
        ent_t e;
        e = '0;
        for (int i = 0; i < 67; i++) begin
            e = {e[ENTRY_W-33:0], $urandom()};
        end
        return e;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            mq[c].delete();
        end
        alloc_m = '0;
        free_m  = '0;
        err_m   = '0;
    endfunction

    // Drive one cycle of stimulus, record what the DUT should present during
    // this cycle, then advance the model across the coming edge.
    task automatic cyc(input logic we, input logic [CH_W-1:0] wc, input ent_t d,
                       input logic re, input logic [CH_W-1:0] rc, input logic [NUM_CH-1:0] fl);
        exp_t              e;
        logic              pop_ok;
        logic              push_ok;
        logic [NUM_CH-1:0] errset;
        @(posedge clk);
        #1;
        wr_en = we; wr_ch = wc; din = d;
        rd_en = re; rd_ch = rc; flush = fl;

        e.alloc = alloc_m;
        e.free  = free_m;
        e.err   = err_m;
        e.cnt   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            e.empty[c] = (mq[c].size() == 0);
            e.full[c]  = (mq[c].size() == DEPTH);
            e.afull[c] = (mq[c].size() >= AFULL_LVL);
            e.cnt[c*CNT_W +: CNT_W] = CNT_W'(mq[c].size());
        end
        e.vld  = (mq[rc].size() != 0);
        e.dout = e.vld ? mq[rc][0] : '0;
        expq.push_back(e);

        pop_ok  = re && (mq[rc].size() != 0) && !fl[rc];
        push_ok = we && !fl[wc] && ((mq[wc].size() < DEPTH) || (pop_ok && rc == wc));
        errset  = '0;
        if (we && !push_ok)            errset[wc] = 1'b1;
        if (re && mq[rc].size() == 0)  errset[rc] = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (fl[c]) mq[c].delete();
        end
        if (pop_ok)  void'(mq[rc].pop_front());
        if (push_ok) mq[wc].push_back(d);
        alloc_m = push_ok ? (NUM_CH'(1) << wc) : '0;
        free_m  = pop_ok  ? (NUM_CH'(1) << rc) : '0;
        err_m   = (err_m & ~fl) | errset;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"}, 64'(count), 64'(0));
        chk({tag, "_empty"}, 64'(empty), 64'({NUM_CH{1'b1}}));
        chk({tag, "_full"},  64'(full), 64'(0));
        chk({tag, "_afull"}, 64'(almost_full), 64'(0));
        chk({tag, "_alloc"}, 64'(alloc_gnt), 64'(0));
        chk({tag, "_free"},  64'(free_ack), 64'(0));
        chk({tag, "_vld"},   64'(dout_vld), 64'(0));
`ifdef BURST_VC_FIFO_ERR_EN
        chk({tag, "_err"},   64'(err), 64'(0));
`endif
    endtask

    // Asynchronous pulse in the middle of a cycle, right after an edge that
    // accepted a push, so alloc_gnt is high when reset hits.
    task automatic reset_pulse();
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = '0; rd_ch = '0;
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("alloc_gnt",   64'(alloc_gnt), 64'(e.alloc));
            chk("free_ack",    64'(free_ack), 64'(e.free));
            chk("empty",       64'(empty), 64'(e.empty));
            chk("full",        64'(full), 64'(e.full));
            chk("almost_full", 64'(almost_full), 64'(e.afull));
            chk("count",       64'(count), 64'(e.cnt));
            chk("dout_vld",    64'(dout_vld), 64'(e.vld));
`ifdef BURST_VC_FIFO_ERR_EN
            chk("err",         64'(err), 64'(e.err));
`endif
            if (e.vld) begin
                n_chk++;
                if (dout !== e.dout) begin
                    n_fail++;
                    $display("FAIL dout: got low64 %h expected low64 %h at %0t",
                             dout[63:0], e.dout[63:0], $time);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        ent_t a, b, c, x;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        wr_en  = 1'b0; wr_ch = '0; din = '0;
        rd_en  = 1'b0; rd_ch = '0; flush = '0;
        model_reset();
        #2 chk_reset_outputs("rst");
        #10 rst_n = 1'b1;

        // Three records through channel 1, popped back in order.
        a = rnd_ent(); b = rnd_ent(); c = rnd_ent();
        cyc(1, 1, a, 0, 1, '0);
        cyc(1, 1, b, 0, 1, '0);
        cyc(1, 1, c, 0, 1, '0);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1, 1, '0);
        cyc(0, 0, '0, 0, 1, '0);

        // Fill channel 0, push into full, then push+pop across the wrap.
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, rnd_ent(), 0, 0, '0);
        cyc(0, 0, '0, 0, 0, '0);
        cyc(1, 0, rnd_ent(), 0, 0, '0);
        for (int i = 0; i < 4; i++) cyc(1, 0, rnd_ent(), 1, 0, '0);

        // Push ch2 while popping the single entry of ch3.
        cyc(1, 3, rnd_ent(), 0, 3, '0);
        cyc(1, 2, rnd_ent(), 1, 3, '0);
        cyc(0, 0, '0, 0, 3, '0);

        // Drain ch0, then push+pop on the empty queue.
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, '0, 1, 0, '0);
        x = rnd_ent();
        cyc(1, 0, x, 1, 0, '0);
        cyc(0, 0, '0, 0, 0, '0);
        cyc(0, 0, '0, 1, 0, '0);

        // Flush ch1 holding 5 entries, with a concurrent push to it.
        for (int i = 0; i < 5; i++) cyc(1, 1, rnd_ent(), 0, 1, '0);
        cyc(1, 1, rnd_ent(), 0, 1, 4'b0010);
        cyc(0, 0, '0, 0, 1, '0);
        cyc(0, 0, '0, 0, 2, '0);

        // Half-fill ch0, reset mid-cycle, then push again from scratch.
        for (int i = 0; i < DEPTH / 2; i++) cyc(1, 0, rnd_ent(), 0, 0, '0);
        reset_pulse();
        x = rnd_ent();
        cyc(1, 0, x, 0, 0, '0);
        cyc(0, 0, '0, 0, 0, '0);

        // Random traffic: push-heavy phase, then pop-heavy phase.
        for (int i = 0; i < 2000; i++) begin
            logic [NUM_CH-1:0] fl;
            int                pw, pr;
            pw = (i < 1000) ? 75 : 40;
            pr = (i < 1000) ? 40 : 75;
            for (int k = 0; k < NUM_CH; k++) fl[k] = ($urandom_range(0, 59) == 0);
            cyc($urandom_range(0, 99) < pw, CH_W'($urandom), rnd_ent(),
                $urandom_range(0, 99) < pr, CH_W'($urandom), fl);
        end
        cyc(0, 0, '0, 0, 0, '0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(expq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
